// File: rtl/lut_arith_pkg.sv
// Shared types and helpers for the LUT-mapped vector add/sub primitive.
// Lane widths are passed at run time so one package serves every WIDTH.
package lut_arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    // Clamp value for a w-bit signed lane; neg selects the minimum.
    // Callers keep the low w bits, where ~max is exactly the signed minimum.
    function automatic logic [31:0] sat_clamp(input logic neg, input int w);
        logic [31:0] maxv;
        maxv = (32'h1 << (w - 1)) - 32'h1;
        return neg ? ~maxv : maxv;
    endfunction

    // Lane i of a packed vector of w-bit lanes, right-aligned.
    function automatic logic [31:0] lane_slice(input logic [511:0] v, input int i, input int w);
        return 32'(v >> (i * w));
    endfunction

endpackage

// File: rtl/lut_addsub_lane.sv
// One lane: stage-1 add/sub/accumulate, overflow detection, wrap or clamp,
// and the lane accumulator.
module lut_addsub_lane
    import lut_arith_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y_p1,
    output logic             ovf_p1
);

    logic signed [WIDTH-1:0] a_s, b_s, acc_q;
    logic signed [WIDTH:0]   sum_p0;
    logic signed [WIDTH-1:0] res_p0;
    logic                    ovf_p0;
    logic                    acc_we;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        sum_p0 = '0;
        unique case (op_t'(op))
            OP_ADD: sum_p0 = {a_s[WIDTH-1], a_s} + {b_s[WIDTH-1], b_s};
            OP_SUB: sum_p0 = {a_s[WIDTH-1], a_s} - {b_s[WIDTH-1], b_s};
            OP_ACC: sum_p0 = {acc_q[WIDTH-1], acc_q} + {a_s[WIDTH-1], a_s};
            OP_CLR: sum_p0 = '0;
        endcase
    end

    // Result leaves the signed range exactly when the two top bits disagree.
    assign ovf_p0 = sum_p0[WIDTH] ^ sum_p0[WIDTH-1];
    assign res_p0 = (SATURATE != 0 && ovf_p0) ? WIDTH'(sat_clamp(sum_p0[WIDTH], WIDTH))
                                              : sum_p0[WIDTH-1:0];
    assign acc_we = in_valid && (op_t'(op) == OP_ACC || op_t'(op) == OP_CLR);

    // ---- stage 1 ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            y_p1   <= '0;
            ovf_p1 <= 1'b0;
        end else if (en) begin
            y_p1   <= res_p0;
            ovf_p1 <= ovf_p0;
            if (acc_we)
                acc_q <= res_p0;
        end
    end

endmodule

// File: rtl/lut_vec_addsub_reg.sv
// Vector of independent signed add/sub/accumulate lanes followed by a
// configurable-depth output pipeline with a travelling valid bit.
module lut_vec_addsub_reg
    import lut_arith_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LANES    = 4,
    parameter int STAGES   = 2,
    parameter int SATURATE = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [1:0]             op,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic                   out_valid,
    output logic [LANES*WIDTH-1:0] y,
    output logic [LANES-1:0]       ovf
);

    localparam int VW = LANES * WIDTH;

    logic [VW-1:0]     y_p1;
    logic [LANES-1:0]  ovf_p1;
    logic [STAGES-1:0] vld_pn;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lut_addsub_lane #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_lane (
            .clock    (clock),
            .reset    (reset),
            .en       (en),
            .in_valid (in_valid),
            .op       (op),
            .a        (WIDTH'(lane_slice(512'(a), i, WIDTH))),
            .b        (WIDTH'(lane_slice(512'(b), i, WIDTH))),
            .y_p1     (y_p1[i*WIDTH +: WIDTH]),
            .ovf_p1   (ovf_p1[i])
        );
    end

    // ---- valid pipe, stage 1..STAGES ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pn <= '0;
        end else if (en) begin
            vld_pn[0] <= in_valid;
            for (int k = 1; k < STAGES; k++)
                vld_pn[k] <= vld_pn[k-1];
        end
    end

    assign out_valid = vld_pn[STAGES-1];

    if (STAGES == 1) begin : g_nodly
        assign y   = y_p1;
        assign ovf = ovf_p1;
    end else begin : g_dly
        logic [VW-1:0]    y_pd   [STAGES-1];
        logic [LANES-1:0] ovf_pd [STAGES-1];

        // ---- stages 2..STAGES: pure delay ----
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k < STAGES - 1; k++) begin
                    y_pd[k]   <= '0;
                    ovf_pd[k] <= '0;
                end
            end else if (en) begin
                y_pd[0]   <= y_p1;
                ovf_pd[0] <= ovf_p1;
                for (int k = 1; k < STAGES - 1; k++) begin
                    y_pd[k]   <= y_pd[k-1];
                    ovf_pd[k] <= ovf_pd[k-1];
                end
            end
        end

        assign y   = y_pd[STAGES-2];
        assign ovf = ovf_pd[STAGES-2];
    end

endmodule

// File: tb/tb_lut_vec_addsub_reg.sv
// Directed bench for lut_vec_addsub_reg: wrap and saturating builds at
// STAGES=2, plus STAGES=1 and STAGES=4 builds sharing the same stimulus.
module tb_lut_vec_addsub_reg;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  op = ADD;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic [31:0] y_w, y_s, y_1, y_4;
    logic [3:0]  ovf_w, ovf_s, ovf_1, ovf_4;
    logic        ov_w, ov_s, ov_1, ov_4;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    lut_vec_addsub_reg #(.WIDTH(8), .LANES(4), .STAGES(2), .SATURATE(0)) dut_wrap (
        .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .op(op),
        .a(a), .b(b), .out_valid(ov_w), .y(y_w), .ovf(ovf_w));
    lut_vec_addsub_reg #(.WIDTH(8), .LANES(4), .STAGES(2), .SATURATE(1)) dut_sat (
        .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .op(op),
        .a(a), .b(b), .out_valid(ov_s), .y(y_s), .ovf(ovf_s));
    lut_vec_addsub_reg #(.WIDTH(8), .LANES(4), .STAGES(1), .SATURATE(0)) dut_s1 (
        .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .op(op),
        .a(a), .b(b), .out_valid(ov_1), .y(y_1), .ovf(ovf_1));
    lut_vec_addsub_reg #(.WIDTH(8), .LANES(4), .STAGES(4), .SATURATE(0)) dut_s4 (
        .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .op(op),
        .a(a), .b(b), .out_valid(ov_4), .y(y_4), .ovf(ovf_4));

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic apply(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic v);
        op = o; a = av; b = bv; in_valid = v;
        cyc();
    endtask

    task automatic test_reset();
        in_valid = 1'b1; op = ADD; a = 32'h01020304; b = 32'h01010101;
        cyc();
        cyc();
        tests++;
        if ({y_w, y_s, y_1, y_4} !== 128'h0) begin
            fails++; $display("FAIL reset_y got=%h %h %h %h exp=0", y_w, y_s, y_1, y_4);
        end
        tests++;
        if ({ovf_w, ovf_s, ovf_1, ovf_4, ov_w, ov_s, ov_1, ov_4} !== 20'h0) begin
            fails++; $display("FAIL reset_flags got ovf=%h %h %h %h vld=%b%b%b%b exp=0",
                              ovf_w, ovf_s, ovf_1, ovf_4, ov_w, ov_s, ov_1, ov_4);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (5) cyc();
    endtask

    task automatic test_add_hold();
        int bad = 0;
        op = ADD; a = 32'h08080808; b = 32'hF6F6F6F6; in_valid = 1'b1;
        cyc();
        tests++;
        if (ov_w !== 1'b0) begin
            fails++; $display("FAIL add_latency out_valid after 1 edge got=%b exp=0", ov_w);
        end
        for (int c = 0; c < 5010; c++) begin
            cyc();
            tests++;
            if (y_w !== 32'hFEFEFEFE || ov_w !== 1'b1 || ovf_w !== 4'h0) begin
                fails++; bad++;
                if (bad < 5)
                    $display("FAIL add_hold cyc=%0d got y=%h vld=%b ovf=%h exp y=fefefefe vld=1 ovf=0",
                             c, y_w, ov_w, ovf_w);
            end
        end
        tests++;
        if (y_1 !== 32'hFEFEFEFE) begin
            fails++; $display("FAIL add_s1 got=%h exp=fefefefe", y_1);
        end
    endtask

    task automatic test_sub_ovf();
        apply(SUB, 32'h0580037F, 32'h070103FF, 1'b1);
        cyc();
        tests++;
        if (y_w !== 32'hFE7F0080 || ovf_w !== 4'b0101) begin
            fails++; $display("FAIL sub_wrap got y=%h ovf=%b exp y=fe7f0080 ovf=0101", y_w, ovf_w);
        end
        tests++;
        if (y_s !== 32'hFE80007F || ovf_s !== 4'b0101) begin
            fails++; $display("FAIL sub_sat got y=%h ovf=%b exp y=fe80007f ovf=0101", y_s, ovf_s);
        end
    endtask

    task automatic test_acc();
        logic [31:0] exp_y [6] = '{32'h0, 32'h05050505, 32'h0A0A0A0A, 32'h0F0F0F0F,
                                   32'h14141414, 32'h0};
        apply(CLR, 32'h11111111, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) apply(ACC, 32'h05050505, 32'h77777777, 1'b1);
            else if (i == 4) apply(CLR, 32'h0, 32'h0, 1'b1);
            else apply(ADD, 32'h0, 32'h0, 1'b0);
            tests++;
            if (y_w !== exp_y[i] || ovf_w !== 4'h0) begin
                fails++; $display("FAIL acc_seq step=%0d got y=%h ovf=%h exp y=%h ovf=0",
                                  i, y_w, ovf_w, exp_y[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_y [3] = '{32'h0A0A0A0A, 32'h0F0F0F0F, 32'h14141414};
        apply(CLR, 32'h0, 32'h0, 1'b1);
        apply(ACC, 32'h05050505, 32'h0, 1'b1);
        apply(ACC, 32'h05050505, 32'h0, 1'b1);
        tests++;
        if (y_w !== 32'h05050505) begin
            fails++; $display("FAIL stall_pre got=%h exp=05050505", y_w);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(ACC, 32'h05050505, 32'h0, 1'b1);
            tests++;
            if (y_w !== 32'h05050505 || ov_w !== 1'b1) begin
                fails++; $display("FAIL stall_hold cyc=%0d got y=%h vld=%b exp y=05050505 vld=1",
                                  i, y_w, ov_w);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(ACC, 32'h05050505, 32'h0, 1'b1);
            tests++;
            if (y_w !== exp_y[i]) begin
                fails++; $display("FAIL stall_resume step=%0d got=%h exp=%h", i, y_w, exp_y[i]);
            end
        end
        apply(ADD, 32'h0, 32'h0, 1'b0);
        tests++;
        if (y_w !== 32'h19191919) begin
            fails++; $display("FAIL stall_final got=%h exp=19191919", y_w);
        end
    endtask

    task automatic test_async_reset();
        apply(CLR, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) apply(ACC, 32'h05050505, 32'h0, 1'b1);
        tests++;
        if (y_w !== 32'h0A0A0A0A || ov_w !== 1'b1) begin
            fails++; $display("FAIL rst_pre got y=%h vld=%b exp y=0a0a0a0a vld=1", y_w, ov_w);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (y_w !== 32'h0 || ov_w !== 1'b0 || y_4 !== 32'h0) begin
            fails++; $display("FAIL rst_async got y=%h vld=%b y4=%h exp 0", y_w, ov_w, y_4);
        end
        cyc();
        reset = 1'b1;
        apply(ACC, 32'h01010101, 32'h0, 1'b1);
        tests++;
        if (ov_w !== 1'b0 || y_w !== 32'h0) begin
            fails++; $display("FAIL rst_flush got y=%h vld=%b exp y=0 vld=0", y_w, ov_w);
        end
        apply(ADD, 32'h0, 32'h0, 1'b0);
        tests++;
        if (y_w !== 32'h01010101 || ov_w !== 1'b1) begin
            fails++; $display("FAIL rst_acc_restart got y=%h vld=%b exp y=01010101 vld=1", y_w, ov_w);
        end
    endtask

    task automatic test_valid_pulse();
        repeat (5) apply(ADD, 32'h0, 32'h0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 1) apply(ADD, 32'h01010101, 32'h02020202, 1'b1);
            else apply(ADD, 32'h0, 32'h0, 1'b0);
            tests++;
            if (ov_1 !== (k == 1) || ov_4 !== (k == 4)) begin
                fails++; $display("FAIL pulse edge=%0d got s1=%b s4=%b exp s1=%b s4=%b",
                                  k, ov_1, ov_4, k == 1, k == 4);
            end
            if (k == 4) begin
                tests++;
                if (y_4 !== 32'h03030303) begin
                    fails++; $display("FAIL pulse_y4 got=%h exp=03030303", y_4);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_hold();
        test_sub_ovf();
        test_acc();
        test_stall();
        test_async_reset();
        test_valid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
